// File: rtl/modmul_cs_pkg.sv
// Shared definitions for the modmul carry-save scheduler.
//   W_DEF / LAT_DEF : default operand width and core latency (LAT_DEF matches
//                     the pipelined carry-save multiplier's stage count).
//   tag_entry_t     : {valid, tag} entry tracked alongside each core operation.
//   rr_pick()       : round-robin search from a pointer with wrap-around.
package modmul_cs_pkg;

  localparam int W_DEF    = 64;
  localparam int LAT_DEF  = 8;
  localparam int MAX_REQ  = 16;
  localparam int TAGW_MAX = 4;

  typedef struct packed {
    logic                valid;
    logic [TAGW_MAX-1:0] tag;
  } tag_entry_t;

  typedef struct packed {
    logic                found;
    logic [TAGW_MAX-1:0] idx;
  } rr_pick_t;

  // First set bit of valid_vec at or above ptr, wrapping at n_req-1 -> 0.
  // ptr is always < n_req, so one subtraction is enough to wrap.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]  valid_vec,
                                       input logic [TAGW_MAX-1:0] ptr,
                                       input int                  n_req);
    rr_pick_t            res;
    logic [TAGW_MAX-1:0] cand;
    int                  j;
    res = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= n_req) j = j - n_req;
      cand = TAGW_MAX'(j);
      if (!res.found && (k < n_req) && valid_vec[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/modmul_cs_sched_if.sv
// Client and core handshake bundle of the modmul scheduler.
//   slave  : scheduler view (accepts requests, drives the core, returns results)
//   master : environment view (requesters plus the multiplier core)
interface modmul_cs_sched_if #(
  parameter int N_REQ = 4,
  parameter int W     = modmul_cs_pkg::W_DEF
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic               core_in_valid;
  logic [W-1:0]       core_a;
  logic [W-1:0]       core_b;
  logic               core_out_valid;
  logic [W-1:0]       core_out_r;
  logic [N_REQ-1:0]   rsp_valid;
  logic [W-1:0]       rsp_r;

  modport slave (
    input  req_valid, req_a, req_b, core_out_valid, core_out_r,
    output req_ready, core_in_valid, core_a, core_b, rsp_valid, rsp_r
  );

  modport master (
    output req_valid, req_a, req_b, core_out_valid, core_out_r,
    input  req_ready, core_in_valid, core_a, core_b, rsp_valid, rsp_r
  );
endinterface

// File: rtl/modmul_cs_tagpipe.sv
// LAT-deep {valid, tag} shift register that follows each operation through
// the multiplier core. Flushed by rst.
//   clk, rst  : clock, async active-high reset
//   in_entry  : entry for the operation issued this cycle
//   out_entry : entry whose result the core presents this cycle
//   any_valid : some stage holds a valid entry
module modmul_cs_tagpipe
  import modmul_cs_pkg::*;
#(
  parameter int LAT = LAT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  tag_entry_t in_entry,
  output tag_entry_t out_entry,
  output logic       any_valid
);

  tag_entry_t pipe_q [LAT];
  tag_entry_t pipe_d [LAT];

  always_comb begin
    pipe_d[0] = in_entry;
    for (int i = 1; i < LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
    end else begin
      for (int i = 0; i < LAT; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < LAT; i++) any_valid = any_valid | pipe_q[i].valid;
  end

  assign out_entry = pipe_q[LAT-1];

endmodule

// File: rtl/modmul_cs_sched.sv
// Round-robin scheduler sharing one pipelined carry-save modmul core among
// N_REQ requesters; routes each result back to its owner via a tag pipe.
//   clk, rst  : clock, async active-high reset
//   hold      : suppress new grants, in-flight work drains
//   bus       : requester handshakes, core issue/return, responses (slave)
//   busy      : an operation is in flight
//   err       : sticky core-return / tag-pipe mismatch
// Optional MODMUL_CS_SCHED_STATS_EN adds stats_clr and grant_cnt
// (per-requester 32-bit transfer counters).
module modmul_cs_sched
  import modmul_cs_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = W_DEF,
  parameter int LAT   = LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  modmul_cs_sched_if.slave     bus,
  output logic                 busy,
  output logic                 err
`ifdef MODMUL_CS_SCHED_STATS_EN
  ,
  input  logic                 stats_clr,
  output logic [N_REQ*32-1:0]  grant_cnt
`endif
);

  localparam int TAGW = $clog2(N_REQ);

  logic [TAGW-1:0]     rr_ptr_q, rr_ptr_d;
  logic                core_in_valid_q, core_in_valid_d;
  logic [W-1:0]        core_a_q, core_a_d, core_b_q, core_b_d;
  logic [TAGW_MAX-1:0] issue_tag_q, issue_tag_d;
  logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [W-1:0]        rsp_r_q, rsp_r_d;
  logic                err_q, err_d;

  logic [MAX_REQ-1:0]  valid_ext;
  rr_pick_t            pick;
  logic                xfer;
  logic [N_REQ-1:0]    req_ready;
  tag_entry_t          pipe_in, pipe_out;
  logic                pipe_any;

  // Grant is gated by rst so req_ready reads 0 while reset is asserted.
  always_comb begin
    valid_ext            = '0;
    valid_ext[N_REQ-1:0] = bus.req_valid;
    pick                 = rr_pick(valid_ext, TAGW_MAX'(rr_ptr_q), N_REQ);
    xfer                 = pick.found & ~hold & ~rst;
    req_ready            = '0;
    for (int i = 0; i < N_REQ; i++)
      req_ready[i] = xfer & (pick.idx == TAGW_MAX'(i));
  end

  always_comb begin
    core_in_valid_d = xfer;
    core_a_d        = core_a_q;
    core_b_d        = core_b_q;
    issue_tag_d     = issue_tag_q;
    rr_ptr_d        = rr_ptr_q;
    if (xfer) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (pick.idx == TAGW_MAX'(i)) begin
          core_a_d = bus.req_a[i*W +: W];
          core_b_d = bus.req_b[i*W +: W];
        end
      end
      issue_tag_d = pick.idx;
      rr_ptr_d    = (pick.idx == TAGW_MAX'(N_REQ-1)) ? '0 : TAGW'(pick.idx + 1'b1);
    end
  end

  assign pipe_in = '{valid: core_in_valid_q, tag: issue_tag_q};

  modmul_cs_tagpipe #(.LAT(LAT)) u_tagpipe (
    .clk       (clk),
    .rst       (rst),
    .in_entry  (pipe_in),
    .out_entry (pipe_out),
    .any_valid (pipe_any)
  );

  // Any disagreement between the core strobe and the tag pipe output is an
  // error; an orphaned tag entry simply falls off the end of the pipe.
  always_comb begin
    rsp_valid_d = '0;
    rsp_r_d     = rsp_r_q;
    if (bus.core_out_valid && pipe_out.valid) begin
      for (int i = 0; i < N_REQ; i++)
        rsp_valid_d[i] = (pipe_out.tag == TAGW_MAX'(i));
      rsp_r_d = bus.core_out_r;
    end
    err_d = err_q | (bus.core_out_valid != pipe_out.valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q        <= '0;
      core_in_valid_q <= 1'b0;
      core_a_q        <= '0;
      core_b_q        <= '0;
      issue_tag_q     <= '0;
      rsp_valid_q     <= '0;
      rsp_r_q         <= '0;
      err_q           <= 1'b0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      core_in_valid_q <= core_in_valid_d;
      core_a_q        <= core_a_d;
      core_b_q        <= core_b_d;
      issue_tag_q     <= issue_tag_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_r_q         <= rsp_r_d;
      err_q           <= err_d;
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.core_in_valid = core_in_valid_q;
  assign bus.core_a        = core_a_q;
  assign bus.core_b        = core_b_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_r         = rsp_r_q;
  assign busy              = pipe_any | core_in_valid_q | (|rsp_valid_q);
  assign err               = err_q;

`ifdef MODMUL_CS_SCHED_STATS_EN
  logic [31:0] cnt_q [N_REQ];
  logic [31:0] cnt_d [N_REQ];

  // Clear wins over a same-cycle increment.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stats_clr)         cnt_d[i] = '0;
      else if (req_ready[i]) cnt_d[i] = cnt_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N_REQ; i++) grant_cnt[i*32 +: 32] = cnt_q[i];
  end
`endif

endmodule

// File: doc/modmul_cs_sched.md
Name: modmul_cs_sched

Overview:
- Round-robin scheduler that shares one pipelined carry-save modular multiplier core among N_REQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and issues at most one operation per cycle into the core.
- Tracks each in-flight operation's owner through the core's fixed latency in a tag shift pipeline and routes each result back to its owner.
- Sits between the client blocks and the modmul core in the pipelined datapath.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- W, 64, operand/result width in bits.
- LAT, 8, core latency in cycles from core_in_valid to core_out_valid (>=1).
- TAGW, $clog2(N_REQ), owner tag width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- hold  in  1  when 1, no new grants; in-flight operations drain normally.
- req_valid  in  N_REQ  request valid per requester.
- req_ready  out  N_REQ  grant/accept per requester; one-hot or zero.
- req_a  in  N_REQ*W  operand A, requester i at bits [i*W +: W].
- req_b  in  N_REQ*W  operand B, same packing.
- core_in_valid  out  1  issue strobe to core.
- core_a  out  W  operand A to core.
- core_b  out  W  operand B to core.
- core_out_valid  in  1  core result strobe.
- core_out_r  in  W  core result.
- rsp_valid  out  N_REQ  one-hot result strobe; no backpressure.
- rsp_r  out  W  result data, shared by all requesters.
- busy  out  1  1 while any operation is in flight.
- err  out  1  sticky; core_out_valid seen when the tag pipe has no valid entry at its output stage.

Behaviour:
- Reset values: req_ready=0, core_in_valid=0, core_a=core_b=0, rsp_valid=0, rsp_r=0, busy=0, err=0, rr_ptr=0, tag pipe all invalid.
- Arbitration is combinational within the cycle:
  - Grant the first requester with req_valid=1, searching from rr_ptr upward with wrap-around at N_REQ-1 -> 0.
  - When hold=1, no grant.
  - req_ready[g]=1 only for the granted index. Transfer occurs when req_valid[g] & req_ready[g].
- Issue is registered:
  - On transfer, next cycle core_in_valid=1, core_a=req_a[g], core_b=req_b[g].
  - Otherwise core_in_valid=0 and core_a/core_b hold their last values.
  - Throughput: one operation per cycle.
  - Issue latency: 1 cycle from accept to core_in_valid.
- rr_ptr update: on transfer, rr_ptr <= (g+1) mod N_REQ; otherwise unchanged. A requester that holds req_valid continuously is served at least once every N_REQ transfers.
- Tag pipe: LAT stages of {valid, tag}, advanced every cycle, loaded with {core_in_valid, issued tag}.
- Result routing is registered:
  - If core_out_valid=1 and the tag pipe output stage is valid: next cycle rsp_valid[tag]=1 and rsp_r=core_out_r.
  - Total latency from accept to rsp_valid: LAT+2 cycles.
- Mismatch cases:
  - core_out_valid=1 with the output stage invalid: err <= 1, no rsp_valid.
  - Output stage valid with core_out_valid=0: err <= 1 and that entry is dropped.
- busy = OR of all tag pipe valid bits OR core_in_valid OR any rsp_valid.
- hold asserted mid-stream: the current-cycle grant is suppressed combinationally; in-flight results still return.
- Reset mid-operation: all in-flight operations are discarded and no rsp_valid is generated for them. The core is reset by the same rst.
- A request withdrawn before transfer is legal; the arbiter moves on and rr_ptr does not change.

Optional Feature:
- Macro: MODMUL_CS_SCHED_STATS_EN.
- When defined:
  - Adds output grant_cnt (N_REQ*32): per-requester 32-bit transfer counters, wrapping at 2^32.
  - Adds input stats_clr: synchronous clear to 0 that takes priority over a same-cycle increment.
  - Counters reset to 0.
- When undefined: neither port nor the counters exist; all other behaviour is identical.

Decomposition:
- Shared package modmul_cs_pkg holds:
  - Default W and LAT constants, with LAT matching the pipelined core's stage count.
  - Typedef tag_entry_t as the {valid, tag} struct.
  - Function rr_pick(valid_vec, ptr) returning the grant index and a found flag.
- One sub-module: modmul_cs_tagpipe, the LAT-deep {valid, tag} shift register with flush on rst.
- The arbiter stays inline in the top.

Test Plan:
- Single request, no contention: N_REQ=4, LAT=8; req_valid=4'b0100, a=7, b=9 at cycle 0. Expect req_ready=4'b0100 at cycle 0, core_in_valid at cycle 1, core result returned at cycle 9, rsp_valid=4'b0100 with rsp_r = core result at cycle 10, err=0.
- Round-robin under full load: all four req_valid held high for 8 cycles from rr_ptr=0. Expect grant order 0,1,2,3,0,1,2,3, core_in_valid=1 on 8 consecutive cycles, and responses in the same order LAT+2 cycles after each accept.
- Wrap and skip: rr_ptr=3 with req_valid=4'b0011. Expect grant 0, then rr_ptr=1 and grant 1, then grant 0.
- hold: assert hold for 5 cycles with 3 operations in flight. Expect req_ready=0 throughout, all 3 rsp_valid still delivered, and busy falling once the last response is delivered.
- Reset mid-flight: issue 4 operations, then pulse rst 3 cycles later. Expect all outputs at reset values immediately, no rsp_valid afterwards, and a fresh request served with nominal latency.
- Error path: force core_out_valid=1 with an empty tag pipe. Expect err=1 next cycle and staying 1 until rst; with the stats macro, grant_cnt is unaffected.
